// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating counters for fetch-side prediction
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   if_pc                : fetch PC; pred_hit / pred_taken / pred_target are combinational from it
//   ex_valid, ex_pc      : EX-stage instruction valid and PC
//   ex_is_cond/uncond    : EX instruction is a conditional branch / jal-jalr
//   ex_taken, ex_target  : resolved outcome and target
//   ex_pred_taken/target : prediction carried down the pipeline for the EX instruction
//   ex_mispredict        : flush IF/ID and redirect to ex_redirect_pc
//   branch_count         : resolved branch/jump count
//   mispredict_count     : mispredict count
module branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_cond,
    input  logic        ex_is_uncond,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        ex_mispredict,
    output logic [31:0] ex_redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    logic                valid_tbl  [ENTRIES];
    logic [1:0]          ctr_tbl    [ENTRIES];
    logic                uncond_tbl [ENTRIES];
    logic [TAG_BITS-1:0] tag_tbl    [ENTRIES];
    logic [31:0]         target_tbl [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0]   if_tag, ex_tag;
    logic                  if_hit, ex_hit, br;
    logic                  unused_pc_bits;

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign if_tag = if_pc[31:INDEX_BITS+2];
    assign ex_idx = ex_pc[INDEX_BITS+1:2];
    assign ex_tag = ex_pc[31:INDEX_BITS+2];

    // PCs are word aligned; the low two bits carry no information.
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Prediction: reads the registered tables only, so a same-cycle update
    // to the same index is not visible until the following cycle.
    assign if_hit      = valid_tbl[if_idx] && (tag_tbl[if_idx] == if_tag);
    assign pred_hit    = !rst && if_hit;
    assign pred_taken  = pred_hit && (uncond_tbl[if_idx] || ctr_tbl[if_idx][1]);
    assign pred_target = pred_taken ? target_tbl[if_idx] : if_pc + 32'd4;

    // Resolution
    assign br             = ex_valid && (ex_is_cond || ex_is_uncond);
    assign ex_hit         = valid_tbl[ex_idx] && (tag_tbl[ex_idx] == ex_tag);
    assign ex_redirect_pc = (br && ex_taken) ? ex_target : ex_pc + 32'd4;
    assign ex_mispredict  = !rst && ex_valid &&
                            ((br && (ex_taken != ex_pred_taken)) ||
                             (br && ex_taken && (ex_target != ex_pred_target)) ||
                             (!br && ex_pred_taken));

    // Valid bits, counters and statistics (reset state)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_tbl[i] <= 1'b0;
                ctr_tbl[i]   <= 2'b01;
            end
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else begin
            if (br) begin
                if (ex_hit) begin
                    if (ex_taken) begin
                        if (ctr_tbl[ex_idx] != 2'b11)
                            ctr_tbl[ex_idx] <= ctr_tbl[ex_idx] + 2'b01;
                    end else begin
                        if (ctr_tbl[ex_idx] != 2'b00)
                            ctr_tbl[ex_idx] <= ctr_tbl[ex_idx] - 2'b01;
                    end
                end else if (ex_taken) begin
                    // Allocation evicts whatever aliased into this slot.
                    valid_tbl[ex_idx] <= 1'b1;
                    ctr_tbl[ex_idx]   <= 2'b10;
                end
            end else if (ex_valid && ex_pred_taken && ex_hit) begin
                // A non-branch predicted taken means the entry is stale.
                valid_tbl[ex_idx] <= 1'b0;
            end
            branch_count     <= branch_count + {31'd0, br};
            mispredict_count <= mispredict_count + {31'd0, ex_mispredict};
        end
    end

    // Tag/target/uncond payload: meaningless while invalid, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && br && ex_taken) begin
            target_tbl[ex_idx] <= ex_target;
            uncond_tbl[ex_idx] <= ex_is_uncond;
            if (!ex_hit)
                tag_tbl[ex_idx] <= ex_tag;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_cond, ex_is_uncond, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc, branch_count, mispredict_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_is_cond       (ex_is_cond),
        .ex_is_uncond     (ex_is_uncond),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .ex_mispredict    (ex_mispredict),
        .ex_redirect_pc   (ex_redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic c, input logic u,
                          input logic t, input logic [31:0] tgt, input logic pt,
                          input logic [31:0] ptgt);
        ex_valid = v; ex_pc = pc; ex_is_cond = c; ex_is_uncond = u;
        ex_taken = t; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
        #1;
    endtask

    task automatic clear_ex();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        if_pc = 32'h100;
        clear_ex();
        step();
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h104);
        step();
        rst = 1'b0;
        #1;

        // Cold lookup
        check("cold_hit", {31'd0, pred_hit}, 32'd0);
        check("cold_taken", {31'd0, pred_taken}, 32'd0);
        check("cold_target", pred_target, 32'h104);
        check("cold_brcnt", branch_count, 32'd0);
        check("cold_mpcnt", mispredict_count, 32'd0);

        // First taken branch: allocate with ctr=10
        set_ex(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
        check("alloc_mp", {31'd0, ex_mispredict}, 32'd1);
        check("alloc_redirect", ex_redirect_pc, 32'h80);
        step();
        clear_ex();
        check("alloc_hit", {31'd0, pred_hit}, 32'd1);
        check("alloc_taken", {31'd0, pred_taken}, 32'd1);
        check("alloc_target", pred_target, 32'h80);
        check("alloc_mpcnt", mispredict_count, 32'd1);
        check("alloc_brcnt", branch_count, 32'd1);

        // Two correctly predicted taken updates: ctr 10 -> 11 -> 11
        for (int i = 0; i < 2; i++) begin
            set_ex(1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80);
            check("sat_mp", {31'd0, ex_mispredict}, 32'd0);
            step();
        end
        clear_ex();
        check("sat_brcnt", branch_count, 32'd3);
        check("sat_mpcnt", mispredict_count, 32'd1);

        // First not-taken: ctr 11 -> 10, still taken
        set_ex(1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
        check("nt1_mp", {31'd0, ex_mispredict}, 32'd1);
        check("nt1_redirect", ex_redirect_pc, 32'h104);
        step();
        clear_ex();
        check("nt1_taken", {31'd0, pred_taken}, 32'd1);
        check("nt1_target", pred_target, 32'h80);

        // Second not-taken: ctr 10 -> 01, not taken but still a hit
        set_ex(1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
        check("nt2_mp", {31'd0, ex_mispredict}, 32'd1);
        step();
        clear_ex();
        check("nt2_hit", {31'd0, pred_hit}, 32'd1);
        check("nt2_taken", {31'd0, pred_taken}, 32'd0);
        check("nt2_target", pred_target, 32'h104);
        check("nt2_brcnt", branch_count, 32'd5);
        check("nt2_mpcnt", mispredict_count, 32'd3);

        // Aliasing: retrain 0x100, then jal at 0x200 evicts it
        set_ex(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
        step();
        set_ex(1, 32'h200, 0, 1, 1, 32'h40, 0, 32'h204);
        check("jal_mp", {31'd0, ex_mispredict}, 32'd1);
        step();
        clear_ex();
        check("alias_old_hit", {31'd0, pred_hit}, 32'd0);
        if_pc = 32'h200;
        #1;
        check("alias_new_taken", {31'd0, pred_taken}, 32'd1);
        check("alias_new_target", pred_target, 32'h40);
        check("alias_brcnt", branch_count, 32'd7);
        check("alias_mpcnt", mispredict_count, 32'd5);

        // Non-branch at a hit PC predicted taken: invalidate
        set_ex(1, 32'h200, 0, 0, 0, 32'h0, 1, 32'h40);
        check("stale_mp", {31'd0, ex_mispredict}, 32'd1);
        check("stale_redirect", ex_redirect_pc, 32'h204);
        step();
        clear_ex();
        check("stale_hit", {31'd0, pred_hit}, 32'd0);
        check("stale_brcnt", branch_count, 32'd7);
        check("stale_mpcnt", mispredict_count, 32'd6);

        // Same-cycle update and fetch of the same index: no bypass
        if_pc = 32'h104;
        set_ex(1, 32'h104, 1, 0, 1, 32'h500, 0, 32'h108);
        check("same_old_hit", {31'd0, pred_hit}, 32'd0);
        check("same_old_target", pred_target, 32'h108);
        step();
        clear_ex();
        check("same_new_hit", {31'd0, pred_hit}, 32'd1);
        check("same_new_target", pred_target, 32'h500);

        // ex_valid=0 is ignored entirely
        set_ex(0, 32'h100, 1, 0, 1, 32'h80, 1, 32'h999);
        check("inv_mp", {31'd0, ex_mispredict}, 32'd0);
        step();
        clear_ex();
        if_pc = 32'h100;
        #1;
        check("inv_hit", {31'd0, pred_hit}, 32'd0);
        check("inv_brcnt", branch_count, 32'd8);
        check("inv_mpcnt", mispredict_count, 32'd7);

        // Reset mid-run after training
        if_pc = 32'h104;
        rst = 1'b1;
        set_ex(1, 32'h104, 1, 0, 1, 32'h600, 0, 32'h108);
        check("midrst_taken", {31'd0, pred_taken}, 32'd0);
        check("midrst_target", pred_target, 32'h108);
        check("midrst_mp", {31'd0, ex_mispredict}, 32'd0);
        step();
        clear_ex();
        rst = 1'b0;
        #1;
        check("postrst_hit", {31'd0, pred_hit}, 32'd0);
        check("postrst_target", pred_target, 32'h108);
        check("postrst_brcnt", branch_count, 32'd0);
        check("postrst_mpcnt", mispredict_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor for the 5-stage pipeline: a direct-mapped BTB with one 2-bit saturating counter per entry.
- IF stage: predicts next-PC in the same cycle from the fetch PC.
- EX stage: consumes the resolved branch outcome (the jump flag and target from branch resolution). It then trains the tables and flags mispredicts to the hazard/flush logic.

Parameters:
- INDEX_BITS, 6, BTB/counter table index width; table has 2^INDEX_BITS entries.
- TAG_BITS, 30-INDEX_BITS (derived, localparam), tag = pc[31:INDEX_BITS+2].

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- if_pc  input  32  fetch-stage PC (word aligned)
- pred_hit  output  1  valid BTB entry with matching tag for if_pc
- pred_taken  output  1  predicted taken
- pred_target  output  32  predicted next PC
- ex_valid  input  1  EX-stage instruction valid (not bubble/flushed)
- ex_pc  input  32  PC of EX-stage instruction
- ex_is_cond  input  1  EX instruction is beq/bne/blt/bge/bltu/bgeu
- ex_is_uncond  input  1  EX instruction is jal/jalr
- ex_taken  input  1  resolved jump flag
- ex_target  input  32  resolved jump target
- ex_pred_taken  input  1  prediction carried down pipeline for this instruction
- ex_pred_target  input  32  predicted next PC carried down pipeline
- ex_mispredict  output  1  flush IF/ID and redirect
- ex_redirect_pc  output  32  correct next PC
- branch_count  output  32  resolved branch/jump count
- mispredict_count  output  32  mispredict count

Behaviour:
- Index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2].
- Per entry state: valid, tag, target[31:0], uncond, ctr[1:0].
- Prediction is combinational from registered tables and if_pc, with zero-cycle latency:
  - pred_hit = valid[idx] && tag[idx]==if_pc tag.
  - pred_taken = pred_hit && (uncond[idx] || ctr[idx][1]).
  - pred_target = pred_taken ? target[idx] : if_pc+4 (32-bit wrap).
- While rst=1, pred_taken=0 and pred_target=if_pc+4.
- Reset (one cycle, synchronous):
  - All valid=0, ctr=2'b01.
  - branch_count=0, mispredict_count=0.
  - Tags and targets are don't-care.
- Resolution is combinational from EX inputs. Let br = ex_valid && (ex_is_cond || ex_is_uncond).
  - ex_redirect_pc = (br && ex_taken) ? ex_target : ex_pc+4.
  - ex_mispredict = ex_valid && ( (br && ex_taken != ex_pred_taken) || (br && ex_taken && ex_target != ex_pred_target) || (!br && ex_pred_taken) ).
  - ex_mispredict=0 when ex_valid=0 or rst=1.
- Table update on rising edge when not in reset, entry e = index of ex_pc:
  - br && hit && ex_taken: ctr saturating increment (max 2'b11); target<=ex_target; uncond<=ex_is_uncond.
  - br && hit && !ex_taken: ctr saturating decrement (min 2'b00); target unchanged.
  - br && miss && ex_taken: allocate and overwrite any prior occupant. Set valid=1, tag, target=ex_target, uncond=ex_is_uncond, ctr=2'b10.
  - br && miss && !ex_taken: no write.
  - !br && ex_valid && ex_pred_taken: stale entry; if hit, valid<=0.
  - ex_valid=0: no write.
- Counters, 32-bit wrap-around:
  - branch_count += br.
  - mispredict_count += ex_mispredict.
- Same-cycle read/write of the same index: IF sees the pre-update value. There is no bypass.
- An update and a prediction on different indices in the same cycle are independent.
- No internal stall input. The pipeline holds ex_valid=0 for stalled/flushed slots.

Test Plan:
- Reset then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; counters 0.
- EX: ex_pc=0x100, cond, taken, target 0x80, pred_taken=0.
  - Same cycle -> ex_mispredict=1, redirect 0x80.
  - Next cycle if_pc=0x100 -> hit, pred_taken=1, pred_target=0x80; mispredict_count=1.
- Counter saturation and hysteresis on entry 0x100:
  - Two more taken updates -> ctr=2'b11.
  - One not-taken (pred_taken=1) -> mispredict, redirect 0x104, still predicts taken.
  - Second not-taken -> ctr=2'b01, predicts not-taken.
- Aliasing: train 0x100 taken, then jal at 0x100 + (4<<INDEX_BITS)=0x200 taken to 0x40 -> entry replaced.
  - if_pc=0x100 -> pred_hit=0.
  - if_pc=0x200 -> pred_taken=1, target 0x40 (uncond regardless of ctr).
- Non-branch at a hit PC with ex_pred_taken=1 -> ex_mispredict=1, redirect ex_pc+4, entry invalidated next cycle.
- Same-cycle update and fetch of same index -> old prediction returned that cycle, new one following cycle.
- rst asserted mid-run after training -> all lookups miss, counters 0.
- ex_valid=0 with ex_taken=1 -> no mispredict, no table or counter change.
